router_reg_param: RTL and testbench

ROUTER_REG_PARAM -- requirements
Module: router_reg_param

---
 rtl/router_reg_param.sv | 120 ++++++++++++
 tb/tb_router_reg_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/router_reg_param.sv
// Router packet register stage: holds the header, buffers a byte across a
// FIFO-full stall, tracks running parity against the packet parity byte and
// raises status flags for the router controller.
// Optional feature macro: ROUTER_LEN_CHECK_EN (payload length check and
// byte_cnt counter; when undefined len_err and byte_cnt are tied to 0).
module router_reg_param #(
  parameter int unsigned DW        = 8,
  parameter int unsigned ADDR_BITS = 2
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    pkt_valid,
  input  logic                    fifo_full,
  input  logic                    detect_add,
  input  logic                    lfd_state,
  input  logic                    ld_state,
  input  logic                    laf_state,
  input  logic                    full_state,
  input  logic                    rst_int_reg,
  input  logic [DW-1:0]           data_in,
  output logic [DW-1:0]           dout,
  output logic [ADDR_BITS-1:0]    pkt_addr,
  output logic                    low_pkt_valid,
  output logic                    parity_done,
  output logic                    err,
  output logic                    len_err,
  output logic [DW-ADDR_BITS-1:0] byte_cnt
);

  logic [DW-1:0] hdr;
  logic [DW-1:0] full_hold;
  logic [DW-1:0] int_par;
  logic [DW-1:0] pkt_par;

  logic hdr_load;
  logic pay_accept;
  logic par_direct;
  logic par_late;

  // Load/accept strobes shared by several registers
  always_comb begin
    hdr_load   = detect_add && pkt_valid;
    pay_accept = ld_state && pkt_valid && !full_state;
    par_direct = ld_state && !pkt_valid && !fifo_full;
    par_late   = laf_state && low_pkt_valid && !parity_done;
  end

  assign pkt_addr = hdr[ADDR_BITS-1:0];

  // Header and full-hold byte capture
  always_ff @(posedge clock) begin
    if (!resetn || rst_int_reg) begin
      hdr       <= '0;
      full_hold <= '0;
    end else begin
      if (hdr_load)              hdr       <= data_in;
      if (ld_state && fifo_full) full_hold <= data_in;
    end
  end

  // Output byte mux: header first, then live data, then the stalled byte
  always_ff @(posedge clock) begin
    if (!resetn)                     dout <= '0;
    else if (lfd_state)              dout <= hdr;
    else if (ld_state && !fifo_full) dout <= data_in;
    else if (laf_state)              dout <= full_hold;
  end

  // Sticky end-of-packet flags
  always_ff @(posedge clock) begin
    if (!resetn || rst_int_reg) begin
      low_pkt_valid <= 1'b0;
      parity_done   <= 1'b0;
    end else begin
      if (ld_state && !pkt_valid)  low_pkt_valid <= 1'b1;
      if (par_direct || par_late)  parity_done   <= 1'b1;
    end
  end

  // Running parity over header and accepted payload; captured packet parity
  always_ff @(posedge clock) begin
    if (!resetn || rst_int_reg) begin
      int_par <= '0;
      pkt_par <= '0;
    end else begin
      if (lfd_state)       int_par <= int_par ^ hdr;
      else if (pay_accept) int_par <= int_par ^ data_in;
      if (par_direct)      pkt_par <= data_in;
      else if (par_late)   pkt_par <= full_hold;
    end
  end

  // Parity error, evaluated once the parity byte has been captured
  always_ff @(posedge clock) begin
    if (!resetn) err <= 1'b0;
    else         err <= parity_done && (int_par != pkt_par);
  end

`ifdef ROUTER_LEN_CHECK_EN
  localparam int unsigned LW = DW - ADDR_BITS;
  localparam logic [LW-1:0] CNT_MAX = '1;

  // Saturating payload byte counter, restarted with each header
  always_ff @(posedge clock) begin
    if (!resetn || rst_int_reg)                 byte_cnt <= '0;
    else if (lfd_state)                         byte_cnt <= '0;
    else if (pay_accept && byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + LW'(1);
  end

  // Length error against the header length field, same timing as err
  always_ff @(posedge clock) begin
    if (!resetn || rst_int_reg) len_err <= 1'b0;
    else len_err <= parity_done && (byte_cnt != hdr[DW-1:ADDR_BITS]);
  end
`else
  assign byte_cnt = '0;
  assign len_err  = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg_param.sv
// Self-checking bench for router_reg_param (DW=8, ADDR_BITS=2): directed
// packet table, reset corner sequences and randomized packets checked
// against a packet-level reference model.
module tb_router_reg_param;

`ifdef ROUTER_LEN_CHECK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn, pkt_valid, fifo_full, detect_add, lfd_state, ld_state;
  logic       laf_state, full_state, rst_int_reg;
  logic [7:0] data_in, dout;
  logic [1:0] pkt_addr;
  logic       low_pkt_valid, parity_done, err, len_err;
  logic [5:0] byte_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pay_q[$];
  bit         stall_q[$];
  logic [7:0] got_q[$];

  typedef struct {
    logic [7:0]  hdr;
    int          n;
    logic [31:0] pl;
    logic [3:0]  stall;
    bit          par_stall;
    logic [7:0]  par;
    bit          exp_err;
    bit          exp_len;
    logic [5:0]  exp_cnt;
    logic [1:0]  exp_addr;
  } vec_t;

  vec_t vec[5];

  router_reg_param #(.DW(8), .ADDR_BITS(2)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .data_in(data_in), .dout(dout), .pkt_addr(pkt_addr),
    .low_pkt_valid(low_pkt_valid), .parity_done(parity_done), .err(err),
    .len_err(len_err), .byte_cnt(byte_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle();
    pkt_valid = 1'b0; fifo_full = 1'b0; detect_add = 1'b0; lfd_state = 1'b0;
    ld_state = 1'b0; laf_state = 1'b0; full_state = 1'b0; rst_int_reg = 1'b0;
    data_in = 8'h00;
  endtask

  // One controller-style stall: FULL_STATE cycle then LAF cycle that emits the held byte
  task automatic stall_recover();
    ld_state = 1'b0; full_state = 1'b1; fifo_full = 1'b1;
    tick();
    full_state = 1'b0; fifo_full = 1'b0; laf_state = 1'b1;
    tick();
    got_q.push_back(dout);
    laf_state = 1'b0;
  endtask

  // Drive one packet from pay_q/stall_q; records every byte written to dout
  task automatic send_pkt(input logic [7:0] h, input logic [7:0] par, input bit par_stall);
    idle();
    got_q.delete();
    detect_add = 1'b1; pkt_valid = 1'b1; data_in = h;
    tick();
    detect_add = 1'b0; lfd_state = 1'b1;
    data_in = (pay_q.size() > 0) ? pay_q[0] : par;
    tick();
    got_q.push_back(dout);
    lfd_state = 1'b0;
    for (int i = 0; i < pay_q.size(); i++) begin
      ld_state = 1'b1; pkt_valid = 1'b1; data_in = pay_q[i]; fifo_full = stall_q[i];
      tick();
      if (stall_q[i]) stall_recover();
      else got_q.push_back(dout);
    end
    ld_state = 1'b1; pkt_valid = 1'b0; data_in = par; fifo_full = par_stall;
    tick();
    if (par_stall) stall_recover();
    else got_q.push_back(dout);
    idle();
  endtask

  // Output stream must be header, payload in order, then parity byte
  task automatic check_stream(input logic [7:0] h, input logic [7:0] par);
    logic [7:0] exp_q[$];
    exp_q.push_back(h);
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    exp_q.push_back(par);
    check("dout_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("dout_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // End-of-packet flags, then rst_int_reg clear behaviour
  task automatic post_checks(input bit e_err, input bit e_len, input logic [5:0] e_cnt,
                             input logic [1:0] e_addr, input logic [7:0] last);
    check("parity_done_rise", 32'(parity_done), 32'd1);
    check("err_before", 32'(err), 32'd0);
    tick();
    check("err", 32'(err), 32'(e_err));
    check("len_err", 32'(len_err), LEN_EN ? 32'(e_len) : 32'd0);
    check("byte_cnt", 32'(byte_cnt), LEN_EN ? 32'(e_cnt) : 32'd0);
    check("pkt_addr", 32'(pkt_addr), 32'(e_addr));
    check("low_pkt_valid", 32'(low_pkt_valid), 32'd1);
    check("parity_done", 32'(parity_done), 32'd1);
    rst_int_reg = 1'b1;
    tick();
    rst_int_reg = 1'b0;
    check("rst_int_parity_done", 32'(parity_done), 32'd0);
    check("rst_int_low", 32'(low_pkt_valid), 32'd0);
    check("rst_int_cnt", 32'(byte_cnt), 32'd0);
    check("rst_int_len_err", 32'(len_err), 32'd0);
    check("rst_int_addr", 32'(pkt_addr), 32'd0);
    check("rst_int_dout_kept", 32'(dout), 32'(last));
    check("rst_int_err_lag", 32'(err), 32'(e_err));
    tick();
    check("err_after_rst_int", 32'(err), 32'd0);
  endtask

  task automatic load_vec(input vec_t v);
    pay_q.delete(); stall_q.delete();
    for (int i = 0; i < v.n; i++) begin
      pay_q.push_back(v.pl[8*i +: 8]);
      stall_q.push_back(v.stall[i]);
    end
  endtask

  initial begin
    logic [7:0] h, par, x;
    bit         ps;
    int         n;
    int         cnt;

    vec[0] = '{8'h0D, 3, 32'h00332211, 4'b0000, 1'b0, 8'h0D, 1'b0, 1'b0, 6'd3, 2'd1};
    vec[1] = '{8'h0D, 3, 32'h00332211, 4'b0000, 1'b0, 8'h0E, 1'b1, 1'b0, 6'd3, 2'd1};
    vec[2] = '{8'h0D, 3, 32'h00332211, 4'b0010, 1'b0, 8'h0D, 1'b0, 1'b0, 6'd3, 2'd1};
    vec[3] = '{8'h11, 3, 32'h00332211, 4'b0000, 1'b0, 8'h11, 1'b0, 1'b1, 6'd3, 2'd1};
    vec[4] = '{8'h0D, 3, 32'h00332211, 4'b0000, 1'b1, 8'h0D, 1'b0, 1'b0, 6'd3, 2'd1};

    idle();
    resetn = 1'b0;
    tick();
    tick();
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_addr", 32'(pkt_addr), 32'd0);
    check("reset_flags", 32'({low_pkt_valid, parity_done, err, len_err}), 32'd0);
    check("reset_cnt", 32'(byte_cnt), 32'd0);
    resetn = 1'b1;
    tick();

    // Directed packet table
    for (int v = 0; v < 5; v++) begin
      load_vec(vec[v]);
      send_pkt(vec[v].hdr, vec[v].par, vec[v].par_stall);
      check_stream(vec[v].hdr, vec[v].par);
      post_checks(vec[v].exp_err, vec[v].exp_len, vec[v].exp_cnt, vec[v].exp_addr, vec[v].par);
    end

    // resetn asserted mid-packet, then a clean packet
    idle();
    detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h0D;
    tick();
    detect_add = 1'b0; lfd_state = 1'b1; data_in = 8'h11;
    tick();
    lfd_state = 1'b0; ld_state = 1'b1;
    tick();
    ld_state = 1'b1; data_in = 8'h22; resetn = 1'b0;
    tick();
    resetn = 1'b1;
    idle();
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_addr", 32'(pkt_addr), 32'd0);
    check("midrst_flags", 32'({low_pkt_valid, parity_done, err, len_err}), 32'd0);
    check("midrst_cnt", 32'(byte_cnt), 32'd0);
    load_vec(vec[0]);
    send_pkt(vec[0].hdr, vec[0].par, 1'b0);
    check_stream(vec[0].hdr, vec[0].par);
    post_checks(1'b0, 1'b0, 6'd3, 2'd1, 8'h0D);

    // rst_int_reg wins over a same-cycle header load
    idle();
    rst_int_reg = 1'b1; detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h0D;
    tick();
    idle();
    check("rst_vs_hdr_addr", 32'(pkt_addr), 32'd0);
    lfd_state = 1'b1;
    tick();
    idle();
    check("rst_vs_hdr_dout", 32'(dout), 32'd0);
    tick();

    // Counter saturation: 70 payload bytes against a length field of 63
    pay_q.delete(); stall_q.delete();
    for (int i = 0; i < 70; i++) begin
      pay_q.push_back(8'h01);
      stall_q.push_back(1'b0);
    end
    send_pkt(8'hFE, 8'hFE, 1'b0);
    check_stream(8'hFE, 8'hFE);
    post_checks(1'b0, 1'b0, 6'd63, 2'd2, 8'hFE);

    // Randomized packets vs packet-level model
    for (int p = 0; p < 30; p++) begin
      pay_q.delete(); stall_q.delete();
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < n; i++) begin
        pay_q.push_back(8'($urandom));
        stall_q.push_back($urandom_range(0, 3) == 0);
      end
      ps = ($urandom_range(0, 3) == 0);
      h[1:0] = 2'($urandom_range(0, 3));
      h[7:2] = ($urandom_range(0, 1) == 1) ? 6'(n) : 6'($urandom);
      x = h;
      foreach (pay_q[i]) x = x ^ pay_q[i];
      par = ($urandom_range(0, 1) == 1) ? x : 8'($urandom);
      cnt = (n > 63) ? 63 : n;
      send_pkt(h, par, ps);
      check_stream(h, par);
      post_checks(par != x, h[7:2] != 6'(cnt), 6'(cnt), h[1:0], par);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
